scan_capture: RTL and testbench

SCAN_CAPTURE -- requirements
Module: scan_capture

---
 rtl/scan_capture_pkg.sv | 38 +++
 rtl/scan_capture_if.sv | 20 ++
 rtl/scan_capture_seg_a_hex.sv | 24 ++
 rtl/scan_capture.sv | 147 ++++++++++++++
 tb/tb_scan_capture.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/scan_capture_pkg.sv
// scan_capture_pkg: shared constants and types for the scan_capture block.
// Holds the 7-segment hex glyph table ({g,f,e,d,c,b,a}, active-high),
// the capture FSM state enum and the number of display digits.
package scan_capture_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
  localparam logic [6:0] SEG_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
  localparam logic [6:0] SEG_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG_GLYPH_F = 7'h71;

  // Indexed by hex value: SEG_GLYPHS[n] is the pattern for nibble n.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    SEG_GLYPH_F, SEG_GLYPH_E, SEG_GLYPH_D, SEG_GLYPH_C,
    SEG_GLYPH_B, SEG_GLYPH_A, SEG_GLYPH_9, SEG_GLYPH_8,
    SEG_GLYPH_7, SEG_GLYPH_6, SEG_GLYPH_5, SEG_GLYPH_4,
    SEG_GLYPH_3, SEG_GLYPH_2, SEG_GLYPH_1, SEG_GLYPH_0
  };

  typedef enum logic {
    S_TRACK = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/scan_capture_if.sv
// scan_capture_if: display-scan input bus and captured-frame output bus.
// master: drives i_Anodos/i_Seg, observes o_Digitos/o_Valid/o_Err.
// slave : the capture block (consumes the scan, produces the frame).
interface scan_capture_if;
  logic [3:0]  i_Anodos;
  logic [6:0]  i_Seg;
  logic [15:0] o_Digitos;
  logic        o_Valid;
  logic        o_Err;

  modport master (
    output i_Anodos, i_Seg,
    input  o_Digitos, o_Valid, o_Err
  );

  modport slave (
    input  i_Anodos, i_Seg,
    output o_Digitos, o_Valid, o_Err
  );
endinterface

// File: rtl/scan_capture_seg_a_hex.sv
// seg_a_hex: purely combinational 7-segment to hex nibble decoder.
// Ports: i_Seg[6:0] pattern {g,f,e,d,c,b,a}; o_Nibble[3:0] decoded value;
//        o_Match high when i_Seg is one of the 16 hex glyphs (else nibble 0).
module seg_a_hex
  import scan_capture_pkg::*;
(
  input  logic [6:0] i_Seg,
  output logic [3:0] o_Nibble,
  output logic       o_Match
);

  always_comb begin
    o_Nibble = 4'h0;
    o_Match  = 1'b0;
    // Glyphs are all distinct, so at most one entry can hit.
    for (int i = 0; i < 16; i++) begin
      if (i_Seg == SEG_GLYPHS[i]) begin
        o_Nibble = 4'(i);
        o_Match  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_capture.sv
// scan_capture: samples a multiplexed 4-digit 7-segment scan and rebuilds the
// displayed hex value. Ports: i_Clk, i_Reset (async, active-low), bus (slave
// modport: i_Anodos, i_Seg in; o_Digitos, o_Valid, o_Err out). Optional
// feature macro SCAN_CAPTURE_ERRCNT_EN adds o_ErrCnt, a saturating error count.
module scan_capture
  import scan_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  scan_capture_if.slave    bus
`ifdef SCAN_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0]       o_ErrCnt
`endif
);

  // Evaluation fires on the same cycle the counter steps to STABLE_CYCLES-1,
  // i.e. on the STABLE_CYCLES-th identical sample.
  localparam logic [3:0] LP_EVAL_CNT = 4'(STABLE_CYCLES - 2);

  logic [3:0]  r_AnSync1, r_AnSync2, r_AnPrev;
  logic [6:0]  r_SegSync1, r_SegSync2, r_SegPrev;
  logic [3:0]  r_Cnt;
  state_t      r_State;
  logic        r_Err;
  logic [15:0] r_Slots;
  logic [3:0]  r_Done;
  logic [15:0] r_Digitos;
  logic        r_Valid;

  logic        w_Same, w_Eval, w_OneHot, w_Multi, w_Capture, w_ErrNow;
  logic [3:0]  w_Nibble;
  logic        w_Match;
  logic [1:0]  w_Idx;
  logic [3:0]  w_DoneBase;

  seg_a_hex u_seg_a_hex (
    .i_Seg    (r_SegSync2),
    .o_Nibble (w_Nibble),
    .o_Match  (w_Match)
  );

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_AnSync1  <= '0;
      r_AnSync2  <= '0;
      r_SegSync1 <= '0;
      r_SegSync2 <= '0;
    end else begin
      r_AnSync1  <= bus.i_Anodos;
      r_AnSync2  <= r_AnSync1;
      r_SegSync1 <= bus.i_Seg;
      r_SegSync2 <= r_SegSync1;
    end
  end

  assign w_Same    = (r_AnSync2 == r_AnPrev) && (r_SegSync2 == r_SegPrev);
  assign w_Eval    = (r_State == S_TRACK) && w_Same && (r_Cnt == LP_EVAL_CNT);
  assign w_OneHot  = (r_AnSync2 != 4'h0) && ((r_AnSync2 & (r_AnSync2 - 4'h1)) == 4'h0);
  assign w_Multi   = (r_AnSync2 != 4'h0) && !w_OneHot;
  assign w_Capture = w_Eval && w_OneHot && w_Match;
  assign w_ErrNow  = w_Eval && (w_Multi || (w_OneHot && !w_Match));

  always_comb begin
    w_Idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_AnSync2[i]) w_Idx = 2'(i);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_State   <= S_TRACK;
      r_Cnt     <= '0;
      r_AnPrev  <= '0;
      r_SegPrev <= '0;
      r_Err     <= 1'b0;
    end else begin
      r_AnPrev  <= r_AnSync2;
      r_SegPrev <= r_SegSync2;
      r_Err     <= w_ErrNow;
      case (r_State)
        S_TRACK: begin
          if (!w_Same) begin
            r_Cnt <= '0;
          end else begin
            if (r_Cnt != 4'hF) r_Cnt <= r_Cnt + 4'h1;
            if (w_Eval) r_State <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!w_Same) begin
            r_Cnt   <= '0;
            r_State <= S_TRACK;
          end
        end
        default: begin
          r_Cnt   <= '0;
          r_State <= S_TRACK;
        end
      endcase
    end
  end

  // A full flag set clears this cycle; a coincident capture lands in the
  // next frame's flags.
  assign w_DoneBase = (r_Done == 4'hF) ? 4'h0 : r_Done;

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Slots   <= '0;
      r_Done    <= '0;
      r_Digitos <= '0;
      r_Valid   <= 1'b0;
    end else begin
      r_Valid <= (r_Done == 4'hF);
      if (r_Done == 4'hF) r_Digitos <= r_Slots;
      if (w_Capture) begin
        r_Slots[{w_Idx, 2'b00} +: 4] <= w_Nibble;
        r_Done <= w_DoneBase | r_AnSync2;
      end else begin
        r_Done <= w_DoneBase;
      end
    end
  end

`ifdef SCAN_CAPTURE_ERRCNT_EN
  logic [7:0] r_ErrCnt;

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_ErrCnt <= '0;
    end else if (w_ErrNow && (r_ErrCnt != 8'hFF)) begin
      r_ErrCnt <= r_ErrCnt + 8'h1;
    end
  end

  assign o_ErrCnt = r_ErrCnt;
`endif

  assign bus.o_Digitos = r_Digitos;
  assign bus.o_Valid   = r_Valid;
  assign bus.o_Err     = r_Err;

endmodule

// File: tb/tb_scan_capture.sv
// tb_scan_capture: directed scan vectors for scan_capture; expected frame and
// error events go into a queue, a monitor pops them as o_Valid / o_Err fire.
module tb_scan_capture;
  import scan_capture_pkg::*;

  logic i_Clk;
  logic i_Reset;
`ifdef SCAN_CAPTURE_ERRCNT_EN
  logic [7:0] o_ErrCnt;
`endif

  scan_capture_if bus();

  scan_capture #(.STABLE_CYCLES(4)) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus)
`ifdef SCAN_CAPTURE_ERRCNT_EN
    ,
    .o_ErrCnt(o_ErrCnt)
`endif
  );

  typedef struct {
    bit          is_valid;
    logic [15:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_valid(input logic [15:0] frame);
    ev_t e;
    e.is_valid = 1'b1;
    e.dat      = frame;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_valid = 1'b0;
    e.dat      = 16'h0;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.i_Anodos = an;
    bus.i_Seg    = seg;
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic digit(input int pos, input int val);
    hold(4'(1 << pos), SEG_GLYPHS[val], 8);
  endtask

  task automatic idle(input int n);
    hold(4'h0, 7'h00, n);
  endtask

  // Monitor: every o_Valid / o_Err pulse must match the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge i_Clk);
      if (bus.o_Valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got o_Valid=1 frame %0h, expected no event", bus.o_Digitos);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_valid", 32'(e.is_valid), 32'd1);
          check("frame", 32'(bus.o_Digitos), 32'(e.dat));
        end
      end
      if (bus.o_Err === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_err: got o_Err=1, expected no event");
        end else begin
          e = exp_q.pop_front();
          check("event_kind_err", 32'(e.is_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    i_Reset      = 1'b0;
    bus.i_Anodos = 4'h0;
    bus.i_Seg    = 7'h00;
    repeat (3) @(negedge i_Clk);
    check("reset_digitos", 32'(bus.o_Digitos), 32'h0);
    check("reset_valid", 32'(bus.o_Valid), 32'h0);
    check("reset_err", 32'(bus.o_Err), 32'h0);
`ifdef SCAN_CAPTURE_ERRCNT_EN
    check("reset_errcnt", 32'(o_ErrCnt), 32'h0);
`endif
    i_Reset = 1'b1;
    idle(4);

    // Two full scans of 4,3,2,1: one frame each.
    for (int s = 0; s < 2; s++) begin
      push_valid(16'h4321);
      digit(3, 4); digit(2, 3); digit(1, 2); digit(0, 1);
    end
    idle(10);
    check("scan_events_done", 32'(exp_q.size()), 32'd0);

    // Overwrite anode 3 (9 then 5) and a 2-cycle all-on glitch mid-digit.
    push_valid(16'h5678);
    digit(3, 9); digit(3, 5);
    digit(2, 6);
    hold(4'b0100, 7'b1111111, 2);
    digit(2, 6);
    check("glitch_frame_unchanged", 32'(bus.o_Digitos), 32'h4321);
    digit(1, 7); digit(0, 8);
    idle(10);
    check("glitch_events_done", 32'(exp_q.size()), 32'd0);

    // Two anodes at once: one error, no frame.
    push_err();
    hold(4'b0011, SEG_GLYPH_1, 6);
    idle(10);
    check("multi_anode_events_done", 32'(exp_q.size()), 32'd0);

    // Unknown glyph on anode 0: error and slot 0 stays not-done.
    push_err();
    hold(4'b0001, 7'b0000001, 6);
    idle(4);
    digit(3, 9); digit(2, 10); digit(1, 11);
    idle(10);
    check("bad_glyph_no_frame", 32'(exp_q.size()), 32'd0);
    push_valid(16'h9ABC);
    digit(0, 12);
    idle(10);
    check("bad_glyph_events_done", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame: captured flags are lost.
    digit(3, 1); digit(2, 2); digit(1, 3);
    i_Reset = 1'b0;
    #1;
    check("midreset_digitos", 32'(bus.o_Digitos), 32'h0);
    check("midreset_valid", 32'(bus.o_Valid), 32'h0);
    idle(3);
    i_Reset = 1'b1;
    idle(4);
    digit(0, 4); digit(1, 3);
    idle(10);
    check("after_reset_no_frame", 32'(exp_q.size()), 32'd0);
    check("after_reset_digitos", 32'(bus.o_Digitos), 32'h0);
    push_valid(16'hDE34);
    digit(3, 13); digit(2, 14);
    idle(10);
    check("after_reset_events_done", 32'(exp_q.size()), 32'd0);

`ifdef SCAN_CAPTURE_ERRCNT_EN
    for (int i = 0; i < 300; i++) begin
      push_err();
      hold((i % 2) ? 4'b0011 : 4'b0110, SEG_GLYPH_1, 5);
    end
    idle(10);
    check("errcnt_saturated", 32'(o_ErrCnt), 32'hFF);
    push_err();
    hold(4'b1100, SEG_GLYPH_2, 6);
    idle(20);
    check("errcnt_held", 32'(o_ErrCnt), 32'hFF);
    check("errcnt_events_done", 32'(exp_q.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
